// File: rtl/occupancy_scoreboard_mc_if.sv
// Bundle of scoreboard stimulus and result signals for occupancy_scoreboard_mc.
// The master side drives pulses and counts; the slave side is the scoreboard itself.
interface occupancy_scoreboard_mc_if #(
  parameter int LANES   = 2,
  parameter int COUNT_W = 4,
  parameter int ERR_W   = 16
);
  logic                 check_en;
  logic                 clr_stats;
  logic [LANES-1:0]     inc_exp;
  logic [LANES-1:0]     dec_exp;
  logic [LANES-1:0]     enter;
  logic [LANES-1:0]     exit;
  logic [COUNT_W-1:0]   count_exp;
  logic [COUNT_W-1:0]   count;
  logic [ERR_W-1:0]     error_count;
  logic [2*LANES-1:0]   err_missing;
  logic [2*LANES-1:0]   err_unexpected;
  logic [2*LANES-1:0]   err_overlap;
  logic                 err_count;
  logic                 pending;
  logic                 pass;

  modport master (
    output check_en, clr_stats, inc_exp, dec_exp, enter, exit, count_exp, count,
    input  error_count, err_missing, err_unexpected, err_overlap, err_count, pending, pass
  );

  modport slave (
    input  check_en, clr_stats, inc_exp, dec_exp, enter, exit, count_exp, count,
    output error_count, err_missing, err_unexpected, err_overlap, err_count, pending, pass
  );
endinterface

// File: rtl/occupancy_scoreboard_mc.sv
// Multi-lane occupancy checker: per-(lane,direction) latency-window trackers, quiescent
// count compare, saturating error counter and sticky error flags.
//
// state   | meaning
// IDLE    | no expectation outstanding
// WAIT    | expectation seen, waiting up to MAX_LAT cycles for the DUT pulse
module occupancy_scoreboard_mc #(
  parameter int LANES   = 2,
  parameter int COUNT_W = 4,
  parameter int MAX_LAT = 2,
  parameter int ERR_W   = 16
) (
  input logic clk,
  input logic reset,
  occupancy_scoreboard_mc_if.slave bus
);

  localparam int NT    = 2 * LANES;
  localparam int TMR_W = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;
  localparam int N_W   = $clog2(NT + 2);
  localparam int SUM_W = ERR_W + N_W;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((MAX_LAT > 0) ? MAX_LAT - 1 : 0);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  logic [NT-1:0]      st_q, st_d;
  logic [TMR_W-1:0]   tmr_q [NT];
  logic [TMR_W-1:0]   tmr_d [NT];

  logic [NT-1:0]      exp_v, act_v;
  logic [NT-1:0]      new_miss, new_unexp, new_ovl;
  logic               cnt_bad;
  logic               all_idle;
  logic [COUNT_W-1:0] cnt_diff;
  logic [N_W-1:0]     n_err;
  logic [SUM_W-1:0]   err_sum;

  logic [ERR_W-1:0]   error_count_q, error_count_d;
  logic [NT-1:0]      err_missing_q, err_unexpected_q, err_overlap_q;
  logic               err_count_q;
  logic               pending_q, pass_q;

  // Lower half of each vector is the enter direction, upper half the exit direction.
  assign exp_v    = {bus.dec_exp, bus.inc_exp};
  assign act_v    = {bus.exit, bus.enter};
  assign cnt_diff = bus.count ^ bus.count_exp;

  always_comb begin
    st_d      = st_q;
    tmr_d     = tmr_q;
    new_miss  = '0;
    new_unexp = '0;
    new_ovl   = '0;
    cnt_bad   = 1'b0;
    all_idle  = 1'b1;
    if (bus.check_en) begin
      for (int t = 0; t < NT; t++) begin
        if (st_q[t] == ST_IDLE) begin
          if (exp_v[t] && !act_v[t]) begin
            if (MAX_LAT > 0) begin
              st_d[t]  = ST_WAIT;
              tmr_d[t] = '0;
            end else begin
              new_miss[t] = 1'b1;
            end
          end else if (!exp_v[t] && act_v[t]) begin
            new_unexp[t] = 1'b1;
          end
        end else begin
          if (act_v[t]) begin
            if (exp_v[t]) tmr_d[t] = '0;
            else          st_d[t]  = ST_IDLE;
          end else if (exp_v[t]) begin
            new_ovl[t] = 1'b1;
            tmr_d[t]   = '0;
          end else if (tmr_q[t] == TMR_LAST) begin
            new_miss[t] = 1'b1;
            st_d[t]     = ST_IDLE;
          end else begin
            tmr_d[t] = tmr_q[t] + TMR_W'(1);
          end
        end
      end
      for (int t = 0; t < NT; t++) begin
        if (st_d[t] != ST_IDLE) all_idle = 1'b0;
      end
      cnt_bad = all_idle && (|cnt_diff);
    end
  end

  always_comb begin
    n_err = N_W'(cnt_bad);
    for (int t = 0; t < NT; t++) begin
      n_err = n_err + N_W'(new_miss[t]) + N_W'(new_unexp[t]) + N_W'(new_ovl[t]);
    end
    // A clear drops the old total but still accounts for this cycle's errors.
    err_sum = (bus.clr_stats ? '0 : SUM_W'(error_count_q)) + SUM_W'(n_err);
    if (err_sum > SUM_W'(ERR_MAX)) error_count_d = ERR_MAX;
    else                           error_count_d = err_sum[ERR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q             <= '0;
      for (int t = 0; t < NT; t++) tmr_q[t] <= '0;
      error_count_q    <= '0;
      err_missing_q    <= '0;
      err_unexpected_q <= '0;
      err_overlap_q    <= '0;
      err_count_q      <= 1'b0;
      pending_q        <= 1'b0;
      pass_q           <= 1'b1;
    end else begin
      st_q             <= st_d;
      for (int t = 0; t < NT; t++) tmr_q[t] <= tmr_d[t];
      error_count_q    <= error_count_d;
      err_missing_q    <= (bus.clr_stats ? '0 : err_missing_q)    | new_miss;
      err_unexpected_q <= (bus.clr_stats ? '0 : err_unexpected_q) | new_unexp;
      err_overlap_q    <= (bus.clr_stats ? '0 : err_overlap_q)    | new_ovl;
      err_count_q      <= (bus.clr_stats ? 1'b0 : err_count_q)    | cnt_bad;
      pending_q        <= |st_d;
      pass_q           <= (error_count_d == '0) && !(|st_d);
    end
  end

  assign bus.error_count    = error_count_q;
  assign bus.err_missing    = err_missing_q;
  assign bus.err_unexpected = err_unexpected_q;
  assign bus.err_overlap    = err_overlap_q;
  assign bus.err_count      = err_count_q;
  assign bus.pending        = pending_q;
  assign bus.pass           = pass_q;

endmodule

// File: tb/tb_occupancy_scoreboard_mc.sv
// Bench for occupancy_scoreboard_mc: directed scenarios then random traffic, all checked
// against a deadline-based reference model of the expectation/pulse rules.
module tb_occupancy_scoreboard_mc;
  localparam int L   = 2;
  localparam int CW  = 4;
  localparam int ML  = 2;
  localparam int EW  = 3;
  localparam int NT  = 2 * L;
  localparam int EMX = (1 << EW) - 1;

  logic clk;
  logic reset;

  occupancy_scoreboard_mc_if #(.LANES(L), .COUNT_W(CW), .ERR_W(EW)) bus ();

  occupancy_scoreboard_mc #(.LANES(L), .COUNT_W(CW), .MAX_LAT(ML), .ERR_W(EW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: per tracker the enabled-cycle number by which the DUT pulse must arrive, -1 if none.
  int deadline [NT];
  int ecyc;
  int m_ec;
  logic [NT-1:0] m_miss, m_unexp, m_ovl;
  logic m_cnt, m_pend, m_pass;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < NT; t++) deadline[t] = -1;
    m_ec = 0; m_miss = '0; m_unexp = '0; m_ovl = '0; m_cnt = 1'b0;
    m_pend = 1'b0; m_pass = 1'b1;
  endtask

  task automatic model_step(input logic ce, input logic clr,
                            input logic [NT-1:0] ev, input logic [NT-1:0] av,
                            input logic cbad);
    int n;
    logic [NT-1:0] nm, nu, no;
    logic idle, nc;
    n = 0; nm = '0; nu = '0; no = '0; nc = 1'b0;
    if (ce) begin
      ecyc++;
      for (int t = 0; t < NT; t++) begin
        if (deadline[t] < 0) begin
          if (ev[t] && !av[t]) begin
            if (ML > 0) deadline[t] = ecyc + ML;
            else nm[t] = 1'b1;
          end else if (av[t] && !ev[t]) nu[t] = 1'b1;
        end else if (av[t]) begin
          deadline[t] = ev[t] ? ecyc + ML : -1;
        end else if (ev[t]) begin
          no[t] = 1'b1;
          deadline[t] = ecyc + ML;
        end else if (ecyc >= deadline[t]) begin
          nm[t] = 1'b1;
          deadline[t] = -1;
        end
      end
      idle = 1'b1;
      for (int t = 0; t < NT; t++) if (deadline[t] >= 0) idle = 1'b0;
      nc = idle && cbad;
    end
    n = $countones(nm) + $countones(nu) + $countones(no) + (nc ? 1 : 0);
    m_ec = (clr ? 0 : m_ec) + n;
    if (m_ec > EMX) m_ec = EMX;
    m_miss  = (clr ? '0 : m_miss)  | nm;
    m_unexp = (clr ? '0 : m_unexp) | nu;
    m_ovl   = (clr ? '0 : m_ovl)   | no;
    m_cnt   = (clr ? 1'b0 : m_cnt) | nc;
    m_pend = 1'b0;
    for (int t = 0; t < NT; t++) if (deadline[t] >= 0) m_pend = 1'b1;
    m_pass = (m_ec == 0) && !m_pend;
  endtask

  task automatic step(input logic rst_n, input logic ce, input logic clr,
                      input logic [L-1:0] ie, input logic [L-1:0] de,
                      input logic [L-1:0] en, input logic [L-1:0] ex,
                      input logic [CW-1:0] cexp, input logic [CW-1:0] cnt);
    reset         = rst_n;
    bus.check_en  = ce;
    bus.clr_stats = clr;
    bus.inc_exp   = ie;
    bus.dec_exp   = de;
    bus.enter     = en;
    bus.exit      = ex;
    bus.count_exp = cexp;
    bus.count     = cnt;
    if (!rst_n) model_reset();
    else model_step(ce, clr, {de, ie}, {ex, en}, cexp != cnt);
    @(posedge clk);
    #1;
    chk("error_count",    32'(bus.error_count),    32'(m_ec));
    chk("err_missing",    32'(bus.err_missing),    32'(m_miss));
    chk("err_unexpected", 32'(bus.err_unexpected), 32'(m_unexp));
    chk("err_overlap",    32'(bus.err_overlap),    32'(m_ovl));
    chk("err_count",      32'(bus.err_count),      32'(m_cnt));
    chk("pending",        32'(bus.pending),        32'(m_pend));
    chk("pass",           32'(bus.pass),           32'(m_pass));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, '0, '0, '0, '0, 4'd5, 4'd5);
  endtask

  initial begin
    logic [L-1:0] ie, de, en, ex;
    logic [CW-1:0] ce_v, cn_v;
    ecyc = 0;
    model_reset();
    reset = 1'b0;
    step(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, 4'd0, 4'd0);
    step(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, 4'd0, 4'd0);
    chk("reset_pass", 32'(bus.pass), 32'd1);
    chk("reset_ec",   32'(bus.error_count), 32'd0);

    // Clean traffic: lane0 enter one cycle late, lane1 exit same cycle.
    idle(2);
    step(1'b1, 1'b1, 1'b0, 2'b01, '0, '0, '0, 4'd1, 4'd0);
    chk("clean_pending", 32'(bus.pending), 32'd1);
    step(1'b1, 1'b1, 1'b0, '0, '0, 2'b01, '0, 4'd1, 4'd1);
    step(1'b1, 1'b1, 1'b0, '0, 2'b10, '0, 2'b10, 4'd0, 4'd0);
    chk("clean_pass", 32'(bus.pass), 32'd1);

    // Missing pulse on lane1 enter, with the model count also moved on.
    step(1'b1, 1'b1, 1'b0, 2'b10, '0, '0, '0, 4'd1, 4'd0);
    idle(2);
    chk("missing_flag", 32'(bus.err_missing[1]), 32'd1);

    // Unexpected exit on lane0, then a double expectation on lane0 enter.
    step(1'b1, 1'b1, 1'b1, '0, '0, '0, 2'b01, 4'd5, 4'd5);
    chk("unexp_flag", 32'(bus.err_unexpected[2]), 32'd1);
    step(1'b1, 1'b1, 1'b0, 2'b01, '0, '0, '0, 4'd5, 4'd5);
    idle(1);
    step(1'b1, 1'b1, 1'b0, 2'b01, '0, '0, '0, 4'd5, 4'd5);
    chk("overlap_flag", 32'(bus.err_overlap[0]), 32'd1);
    idle(3);

    // Count mismatch hidden while lane0 waits, reported once quiescent.
    step(1'b1, 1'b1, 1'b1, 2'b01, '0, '0, '0, 4'd4, 4'd3);
    step(1'b1, 1'b1, 1'b0, '0, '0, '0, '0, 4'd4, 4'd3);
    chk("count_gated", 32'(bus.err_count), 32'd0);
    step(1'b1, 1'b1, 1'b0, '0, '0, 2'b01, '0, 4'd4, 4'd3);
    step(1'b1, 1'b1, 1'b0, '0, '0, '0, '0, 4'd4, 4'd3);
    chk("count_err", 32'(bus.error_count), 32'd2);

    // Saturation, clean clear, clear racing two fresh errors.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, '0, '0, 2'b01, '0, 4'd5, 4'd5);
    chk("sat", 32'(bus.error_count), 32'd7);
    step(1'b1, 1'b1, 1'b1, '0, '0, '0, '0, 4'd5, 4'd5);
    chk("clr_zero", 32'(bus.error_count), 32'd0);
    step(1'b1, 1'b1, 1'b1, '0, '0, 2'b11, '0, 4'd5, 4'd5);
    chk("clr_race", 32'(bus.error_count), 32'd2);

    // Frozen checker ignores pulses.
    step(1'b1, 1'b0, 1'b0, 2'b01, '0, 2'b10, 2'b01, 4'd1, 4'd9);

    // Reset while a tracker waits: no missing error afterwards.
    step(1'b1, 1'b1, 1'b0, 2'b10, '0, '0, '0, 4'd5, 4'd5);
    step(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, 4'd5, 4'd5);
    idle(4);
    chk("rst_wait_ec", 32'(bus.error_count), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      ie = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
      de = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 3) != 0) ? ie : 2'($urandom_range(0, 3));
      ex = ($urandom_range(0, 3) != 0) ? de : 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) != 0) begin
        en = '0;
        ex = '0;
      end
      ce_v = 4'($urandom);
      cn_v = ($urandom_range(0, 4) != 0) ? ce_v : 4'($urandom);
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 19) == 0), ie, de, en, ex, ce_v, cn_v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
